// File: rtl/bdd_sbox_seq_if.sv
// Handshake bundle between the nibble producer/consumer and the S-box sequencer.
interface bdd_sbox_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_nibble;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_nibble;
    logic       out_err;

    // Sequencer side: takes nibbles in, hands results out.
    modport slave (
        input  in_valid, in_nibble, out_ready,
        output in_ready, out_valid, out_nibble, out_err
    );

    // Environment side: offers nibbles, consumes results.
    modport master (
        output in_valid, in_nibble, out_ready,
        input  in_ready, out_valid, out_nibble, out_err
    );
endinterface

// File: rtl/bdd_sbox_seq.sv
// Precharge/evaluate sequencer for the 4-bit dual-rail BDD S-box.
// One nibble in flight at a time: latch, precharge, evaluate, capture the
// u/c rails, check complementarity, then hold the result until consumed.
module bdd_sbox_seq #(
    parameter int PRE_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bdd_sbox_seq_if.slave        bus,
    output logic                 pre,
    output logic [3:0]           select,
    output logic [3:0]           select_bar,
    output logic                 input0,
    output logic                 input1,
    input  logic [3:0]           u_out,
    input  logic [3:0]           c_out,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int MAX_CYC = (PRE_CYCLES > SETTLE_CYCLES) ? PRE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] PRE_LAST    = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_EVAL, S_DONE} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [3:0]           x, x_n;
    logic                 in_ready, in_ready_n;
    logic                 pre_n;
    logic [3:0]           sel_n, selb_n;
    logic                 out_valid, out_valid_n;
    logic [3:0]           out_nibble, out_nibble_n;
    logic                 out_err, out_err_n;
    logic [ERR_CNT_W-1:0] err_n;
    logic                 rail_fault;

    // Leaf rails of the BDD are constants, independent of reset.
    assign input0 = 1'b0;
    assign input1 = 1'b1;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_nibble = out_nibble;
    assign bus.out_err    = out_err;

    // A healthy slice always drives its two rails to opposite values.
    assign rail_fault = |(u_out ~^ c_out);

    // State and registered-output update; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            x          <= '0;
            in_ready   <= 1'b1;
            pre        <= 1'b0;
            select     <= '0;
            select_bar <= '0;
            out_valid  <= 1'b0;
            out_nibble <= '0;
            out_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            x          <= x_n;
            in_ready   <= in_ready_n;
            pre        <= pre_n;
            select     <= sel_n;
            select_bar <= selb_n;
            out_valid  <= out_valid_n;
            out_nibble <= out_nibble_n;
            out_err    <= out_err_n;
            err_count  <= err_n;
        end
    end

    // Next state and next values of every registered output. Phase and
    // selects default to precharge/all-off so only EVAL can make a MUX conduct.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        x_n          = x;
        in_ready_n   = 1'b0;
        pre_n        = 1'b0;
        sel_n        = '0;
        selb_n       = '0;
        out_valid_n  = out_valid;
        out_nibble_n = out_nibble;
        out_err_n    = out_err;
        err_n        = err_count;

        case (state)
            S_IDLE: begin
                in_ready_n = 1'b1;
                if (bus.in_valid && in_ready) begin
                    x_n        = bus.in_nibble;
                    cnt_n      = '0;
                    in_ready_n = 1'b0;
                    state_n    = S_PRE;
                end
            end
            S_PRE: begin
                if (cnt == PRE_LAST) begin
                    cnt_n   = '0;
                    pre_n   = 1'b1;
                    sel_n   = x;
                    selb_n  = ~x;
                    state_n = S_EVAL;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_EVAL: begin
                if (cnt == SETTLE_LAST) begin
                    // Capture edge: rails are sampled here and nowhere else.
                    cnt_n        = '0;
                    out_nibble_n = u_out;
                    out_err_n    = rail_fault;
                    out_valid_n  = 1'b1;
                    if (rail_fault && (err_count != {ERR_CNT_W{1'b1}}))
                        err_n = err_count + ERR_CNT_W'(1);
                    state_n = S_DONE;
                end else begin
                    cnt_n  = cnt + CNT_W'(1);
                    pre_n  = 1'b1;
                    sel_n  = x;
                    selb_n = ~x;
                end
            end
            S_DONE: begin
                // Circuit sits precharged while the consumer is stalled.
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            default: begin
                state_n    = S_IDLE;
                in_ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_bdd_sbox_seq.sv
// Directed bench for bdd_sbox_seq with a behavioural model of the four
// dual-rail slices (PRESENT S-box) and optional per-bit rail fault injection.
module tb_bdd_sbox_seq;

    localparam int ERR_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pre;
    logic [3:0]       select, select_bar;
    logic             input0, input1;
    logic [3:0]       u_out, c_out;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       fault_mask = 4'h0;

    int vectors     = 0;
    int miscompares = 0;
    int inv_checks  = 0;
    int inv_bad     = 0;

    bdd_sbox_seq_if bus();

    bdd_sbox_seq #(.PRE_CYCLES(1), .SETTLE_CYCLES(2), .ERR_CNT_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .pre(pre), .select(select), .select_bar(select_bar),
        .input0(input0), .input1(input1),
        .u_out(u_out), .c_out(c_out), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] v);
        case (v)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    // Slice model: precharge pulls both rails low, evaluate drives S(x) and
    // its complement; a masked bit copies u onto c to fake a rail fault.
    always_comb begin
        u_out = 4'h0;
        c_out = 4'h0;
        if (pre) begin
            u_out = sbox(select);
            c_out = (~u_out & ~fault_mask) | (u_out & fault_mask);
        end
    end

    // Structural invariants watched on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            inv_checks++;
            if ((select & select_bar) != 4'h0) inv_bad++;
            if (pre && (select_bar != ~select)) inv_bad++;
            if (!pre && (select != 4'h0 || select_bar != 4'h0)) inv_bad++;
            if (input0 !== 1'b0 || input1 !== 1'b1) inv_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] v);
        bus.in_valid  = 1'b1;
        bus.in_nibble = v;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    int         lat, pre_cnt, idx, nres, viol, bad;
    logic       acc;
    logic [3:0] xs [0:3];
    logic [3:0] res [0:2];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_nibble = 4'h0;
        bus.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  bus.in_ready,   1);
        chk("rst_pre",       pre,            0);
        chk("rst_select",    {select, select_bar}, 0);
        chk("rst_out_valid", bus.out_valid,  0);
        chk("rst_out_nib",   bus.out_nibble, 0);
        chk("rst_err_count", err_count,      0);
        chk("rst_leaves",    {input1, input0}, 2'b10);

        // T1: x=0 -> 0xC, three cycles after accept, pre high for two
        send(4'h0);
        lat = 0; pre_cnt = 0;
        while (!bus.out_valid && lat < 20) begin
            if (pre) pre_cnt++;
            tick();
            lat++;
        end
        chk("t1_latency",  lat, 3);
        chk("t1_pre_high", pre_cnt, 2);
        chk("t1_nibble",   bus.out_nibble, 4'hC);
        chk("t1_err",      bus.out_err, 0);
        chk("t1_busy",     bus.in_ready, 0);
        release_out();
        chk("t1_drop",     bus.out_valid, 0);
        chk("t1_ready",    bus.in_ready, 1);

        // T2: back-to-back stream with consumer always ready
        xs[0] = 4'h5; xs[1] = 4'hA; xs[2] = 4'hF; xs[3] = 4'h0;
        bus.out_ready = 1'b1;
        idx = 0; nres = 0; viol = 0;
        for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
            bus.in_valid  = (idx < 3);
            bus.in_nibble = xs[idx];
            @(negedge clk);
            if ((pre || bus.out_valid) && bus.in_ready) viol++;
            if (bus.out_valid && bus.out_ready) begin
                res[nres] = bus.out_nibble;
                nres++;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t2_count", nres, 3);
        chk("t2_res0",  res[0], 4'h0);
        chk("t2_res1",  res[1], 4'hF);
        chk("t2_res2",  res[2], 4'h2);
        chk("t2_busy",  viol, 0);

        // T3: stalled consumer holds the result with the circuit precharged
        tick();
        send(4'h9);
        wait_out(lat);
        chk("t3_latency", lat, 3);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_nibble != 4'hE || bus.out_err) bad++;
            if (pre || select != 4'h0 || select_bar != 4'h0 || bus.in_ready) bad++;
        end
        #1;
        chk("t3_stable",  bad, 0);
        chk("t3_nibble",  bus.out_nibble, 4'hE);
        release_out();
        chk("t3_drop",    bus.out_valid, 0);
        chk("t3_ready",   bus.in_ready, 1);

        // T4: rail fault on bit 2, then a clean operation
        fault_mask = 4'b0100;
        send(4'h3);
        wait_out(lat);
        chk("t4_nibble", bus.out_nibble, 4'hB);
        chk("t4_err",    bus.out_err, 1);
        chk("t4_count",  err_count, 1);
        release_out();
        fault_mask = 4'h0;
        send(4'h7);
        wait_out(lat);
        chk("t4_clean_nib",   bus.out_nibble, 4'hD);
        chk("t4_clean_err",   bus.out_err, 0);
        chk("t4_clean_count", err_count, 1);
        release_out();

        // T5: reset mid-EVAL aborts without emitting a result
        send(4'h1);
        tick();
        chk("t5_in_eval", pre, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_pre",       pre, 0);
        chk("t5_select",    {select, select_bar}, 0);
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_err_count", err_count, 0);
        chk("t5_in_ready",  bus.in_ready, 1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) bad++;
        end
        chk("t5_no_result", bad, 0);

        // T6: every input with an injected fault; counter saturates at 3
        for (int v = 0; v < 16; v++) begin
            fault_mask = 4'b0001 << (v % 4);
            send(4'(v));
            wait_out(lat);
            chk("t6_nibble", bus.out_nibble, sbox(4'(v)));
            chk("t6_err",    bus.out_err, 1);
            chk("t6_count",  err_count, (v + 1 > 3) ? 3 : v + 1);
            release_out();
        end
        fault_mask = 4'h0;

        chk("invariants_seen", (inv_checks > 100) ? 1 : 0, 1);
        chk("invariants", inv_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
